tensor_core_stream_loader: RTL

// - Sequential front/back end for the combinational 4x4 8-bit matrix-multiply tensor core.
// - Accepts a byte stream of operand A (16 elems), then operand B (16 elems), and drives both as

---
 rtl/tensor_core_stream_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tensor_core_stream_loader.sv
// Byte-stream loader/unloader around a combinational DIMxDIM tensor core: streams in A then B, captures the product, streams it out.
// Optional build macro TENSOR_LOADER_TRANSPOSE_B_EN: operand B is loaded column-major.
module tensor_core_stream_loader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIM        = 4
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [DATA_WIDTH-1:0]                       in_data,
   output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]     core_in1,
   output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]     core_in2,
   input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]     core_out,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DATA_WIDTH-1:0]                       out_data,
   output logic                                        out_last,
   output logic                                        busy
);

   localparam int unsigned   N        = DIM * DIM;
   localparam int unsigned   IW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

   state_t                        r_state;
   logic [IW-1:0]                 r_idx;
   logic [N-1:0][DATA_WIDTH-1:0]  r_a;
   logic [N-1:0][DATA_WIDTH-1:0]  r_b;
   logic [N-1:0][DATA_WIDTH-1:0]  r_res;
   logic                          r_in_ready;
   logic                          r_out_valid;
   logic                          r_out_last;
   logic                          r_busy;
   logic [DATA_WIDTH-1:0]         r_out_data;

   logic                          w_in_xfer;
   logic                          w_out_xfer;
   logic                          w_idx_last;
   logic [IW-1:0]                 w_idx_nxt;
   logic [IW-1:0]                 w_b_idx;

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_out_xfer = out_ready & r_out_valid;
   assign w_idx_last = (r_idx == LAST_IDX);
   // Explicit wrap keeps the counter correct when DIM*DIM is not a power of two.
   assign w_idx_nxt  = w_idx_last ? '0 : r_idx + IW'(1);

`ifdef TENSOR_LOADER_TRANSPOSE_B_EN
   assign w_b_idx = IW'((32'(r_idx) % DIM) * DIM + 32'(r_idx) / DIM);
`else
   assign w_b_idx = r_idx;
`endif

   // Flat row-major storage lines up bit-for-bit with the core's [row][col] packing.
   assign core_in1  = r_a;
   assign core_in2  = r_b;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LOAD_A;
         r_idx       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            LOAD_A: begin
               if (w_in_xfer) begin
                  r_a[r_idx] <= in_data;
                  r_idx      <= w_idx_nxt;
                  if (w_idx_last) begin
                     r_state <= LOAD_B;
                     r_busy  <= 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (w_in_xfer) begin
                  r_b[w_b_idx] <= in_data;
                  r_idx        <= w_idx_nxt;
                  if (w_idx_last) begin
                     r_state    <= COMPUTE;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            COMPUTE: begin
               // First result element is taken straight from the core so it is valid on DRAIN entry.
               r_res       <= core_out;
               r_out_data  <= core_out[0][0];
               r_out_valid <= 1'b1;
               r_out_last  <= (LAST_IDX == '0);
               r_state     <= DRAIN;
            end
            DRAIN: begin
               if (w_out_xfer) begin
                  r_idx <= w_idx_nxt;
                  if (w_idx_last) begin
                     r_state     <= LOAD_A;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_data  <= '0;
                     r_in_ready  <= 1'b1;
                     r_busy      <= 1'b0;
                  end else begin
                     r_out_data <= r_res[w_idx_nxt];
                     r_out_last <= (w_idx_nxt == LAST_IDX);
                  end
               end
            end
            default: r_state <= LOAD_A;
         endcase
      end
   end

endmodule
